// File: rtl/multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_controller : Moore control FSM for a multicycle MIPS-style datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             ext_zero,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    EXECUTE, R_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB, HALT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tcnt;
  logic          pc_write_q;
  logic          done_q;
  logic          wait_mem;
  logic          timeout;
  logic          imm_zext;

  assign wait_mem = ((state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE)) && !mem_ready;
  assign timeout  = (MEM_TIMEOUT != 0) && (tcnt == TLAST);
  assign imm_zext = (opcode == OP_ANDI) || (opcode == OP_ORI);

  // Handshake-completion strobes must follow mem_ready in the same cycle.
  assign ir_write   = (state == FETCH) && mem_ready;
  assign pc_write   = pc_write_q || ((state == FETCH) && mem_ready);
  assign instr_done = done_q || ((state == MEM_WRITE) && mem_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = FETCH;
      FETCH:     if (mem_ready) state_nxt = DECODE;
                 else if (timeout) state_nxt = HALT;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:            state_nxt = MEM_ADDR;
          OP_R:                    state_nxt = EXECUTE;
          OP_BEQ:                  state_nxt = BRANCH;
          OP_J:                    state_nxt = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_nxt = IMM_EXEC;
          default:                 state_nxt = HALT;
        endcase
      end
      MEM_ADDR:  state_nxt = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) state_nxt = MEM_WB;
                 else if (timeout) state_nxt = HALT;
      MEM_WB:    state_nxt = FETCH;
      MEM_WRITE: if (mem_ready) state_nxt = FETCH;
                 else if (timeout) state_nxt = HALT;
      EXECUTE:   state_nxt = R_WB;
      R_WB:      state_nxt = FETCH;
      BRANCH:    state_nxt = FETCH;
      JUMP:      state_nxt = FETCH;
      IMM_EXEC:  state_nxt = IMM_WB;
      IMM_WB:    state_nxt = FETCH;
      HALT:      state_nxt = HALT;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      tcnt          <= '0;
      retired       <= '0;
      pc_write_q    <= 1'b0;
      pc_write_cond <= 1'b0;
      i_or_d        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_dst       <= 1'b0;
      reg_write     <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b00;
      alu_op        <= 2'b00;
      pc_source     <= 2'b00;
      ext_zero      <= 1'b0;
      illegal_op    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= (wait_mem && (state_nxt == state)) ? tcnt + TW'(1) : '0;
      if (instr_done) retired <= retired + CNT_W'(1);

      pc_write_q    <= 1'b0;
      pc_write_cond <= 1'b0;
      i_or_d        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_dst       <= 1'b0;
      reg_write     <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b00;
      alu_op        <= 2'b00;
      pc_source     <= 2'b00;
      ext_zero      <= 1'b0;
      illegal_op    <= 1'b0;
      done_q        <= 1'b0;

      case (state_nxt)
        FETCH:     begin mem_read <= 1'b1; alu_src_b <= 2'b01; end
        DECODE:    alu_src_b <= 2'b11;
        MEM_ADDR:  begin alu_src_a <= 1'b1; alu_src_b <= 2'b10; end
        MEM_READ:  begin mem_read <= 1'b1; i_or_d <= 1'b1; end
        MEM_WB:    begin reg_write <= 1'b1; mem_to_reg <= 1'b1; done_q <= 1'b1; end
        MEM_WRITE: begin mem_write <= 1'b1; i_or_d <= 1'b1; end
        EXECUTE:   begin alu_src_a <= 1'b1; alu_op <= 2'b10; end
        R_WB:      begin reg_write <= 1'b1; reg_dst <= 1'b1; done_q <= 1'b1; end
        BRANCH: begin
          alu_src_a     <= 1'b1;
          alu_op        <= 2'b01;
          pc_write_cond <= 1'b1;
          pc_source     <= 2'b01;
          done_q        <= 1'b1;
        end
        JUMP:      begin pc_write_q <= 1'b1; pc_source <= 2'b10; done_q <= 1'b1; end
        IMM_EXEC: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
          alu_op    <= 2'b11;
          ext_zero  <= imm_zext;
        end
        IMM_WB:    begin reg_write <= 1'b1; ext_zero <= imm_zext; done_q <= 1'b1; end
        HALT:      illegal_op <= 1'b1;
        default:   ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// tb_multicycle_controller : scoreboard bench, per-cycle expected outputs
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0, reset_n2 = 1'b0;
  logic [5:0]  opcode = 6'h00, opcode2 = 6'h00;
  logic        mem_ready = 1'b0, mem_ready2 = 1'b0;

  logic pw1, pwc1, iod1, mrd1, mwr1, irw1, m2r1, rd1, rw1, asa1, ez1, ill1, dn1;
  logic [1:0] asb1, aop1, ps1;
  logic [31:0] ret1;
  logic pw2, pwc2, iod2, mrd2, mwr2, irw2, m2r2, rd2, rw2, asa2, ez2, ill2, dn2;
  logic [1:0] asb2, aop2, ps2;
  logic [1:0] ret2;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(255)) dut1 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw1), .pc_write_cond(pwc1), .i_or_d(iod1), .mem_read(mrd1),
    .mem_write(mwr1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rd1),
    .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
    .pc_source(ps1), .ext_zero(ez1), .illegal_op(ill1), .instr_done(dn1),
    .retired(ret1));

  multicycle_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dut2 (
    .clk(clk), .reset_n(reset_n2), .opcode(opcode2), .mem_ready(mem_ready2),
    .pc_write(pw2), .pc_write_cond(pwc2), .i_or_d(iod2), .mem_read(mrd2),
    .mem_write(mwr2), .ir_write(irw2), .mem_to_reg(m2r2), .reg_dst(rd2),
    .reg_write(rw2), .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2),
    .pc_source(ps2), .ext_zero(ez2), .illegal_op(ill2), .instr_done(dn2),
    .retired(ret2));

  logic [18:0] vec1, vec2;
  assign vec1 = {pw1, pwc1, iod1, mrd1, mwr1, irw1, m2r1, rd1, rw1, asa1,
                 asb1, aop1, ps1, ez1, ill1, dn1};
  assign vec2 = {pw2, pwc2, iod2, mrd2, mwr2, irw2, m2r2, rd2, rw2, asa2,
                 asb2, aop2, ps2, ez2, ill2, dn2};

  typedef enum {S_IDLE, S_FETCH, S_DECODE, S_MADDR, S_MREAD, S_MWB, S_MWRITE,
                S_EXEC, S_RWB, S_BR, S_JMP, S_IEX, S_IWB, S_HALT} st_t;

  typedef struct {
    bit          sel;
    logic [18:0] vec;
    logic [31:0] ret;
    string       tag;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_ret[2] = '{0, 0};
  bit    sel = 1'b0;
  logic [5:0] op = 6'h00;

  // Expected output vector for one cycle in a given state, from the control table.
  function automatic logic [18:0] expv(st_t s, logic [5:0] o, logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ez, ill, dn;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ez, ill, dn} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      S_DECODE: asb = 2'b11;
      S_MADDR:  begin asa = 1; asb = 2'b10; end
      S_MREAD:  begin mrd = 1; iod = 1; end
      S_MWB:    begin rw = 1; m2r = 1; dn = 1; end
      S_MWRITE: begin mwr = 1; iod = 1; dn = mr; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; dn = 1; end
      S_BR:     begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; dn = 1; end
      S_JMP:    begin pw = 1; psrc = 2'b10; dn = 1; end
      S_IEX:    begin asa = 1; asb = 2'b10; aop = 2'b11; ez = (o == 6'h0C) || (o == 6'h0D); end
      S_IWB:    begin rw = 1; ez = (o == 6'h0C) || (o == 6'h0D); dn = 1; end
      S_HALT:   ill = 1;
      default:  ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ez, ill, dn};
  endfunction

  task automatic push(st_t s, logic mr);
    exp_t e;
    e.sel = sel;
    e.vec = expv(s, op, mr);
    e.ret = 32'(exp_ret[sel]);
    e.tag = s.name();
    q.push_back(e);
    if (e.vec[0]) exp_ret[sel] = sel ? (exp_ret[sel] + 1) % 4 : exp_ret[sel] + 1;
  endtask

  task automatic cyc(st_t s, logic mr);
    @(posedge clk); #1;
    if (sel) begin mem_ready2 = mr; opcode2 = op; end
    else     begin mem_ready  = mr; opcode  = op; end
    push(s, mr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    if (sel) begin reset_n2 = 1'b0; mem_ready2 = 1'b0; end
    else     begin reset_n  = 1'b0; mem_ready  = 1'b0; end
    @(posedge clk); #1;
    if (sel) reset_n2 = 1'b1; else reset_n = 1'b1;
    exp_ret[sel] = 0;
    push(S_IDLE, 1'b0);
  endtask

  task automatic instr(logic [5:0] o, int w);
    op = o;
    cyc(S_FETCH, 1'b1);
    cyc(S_DECODE, 1'b0);
    case (o)
      6'h00: begin cyc(S_EXEC, 1'b0); cyc(S_RWB, 1'b0); end
      6'h23: begin
        cyc(S_MADDR, 1'b0);
        repeat (w) cyc(S_MREAD, 1'b0);
        cyc(S_MREAD, 1'b1);
        cyc(S_MWB, 1'b0);
      end
      6'h2B: begin
        cyc(S_MADDR, 1'b0);
        repeat (w) cyc(S_MWRITE, 1'b0);
        cyc(S_MWRITE, 1'b1);
      end
      6'h04: cyc(S_BR, 1'b1);
      6'h02: cyc(S_JMP, 1'b1);
      6'h08, 6'h0C, 6'h0D: begin cyc(S_IEX, 1'b1); cyc(S_IWB, 1'b1); end
      default: for (int i = 0; i <= w; i++) cyc(S_HALT, 1'(i));
    endcase
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [18:0] av;
      logic [31:0] ar;
      e  = q.pop_front();
      av = e.sel ? vec2 : vec1;
      ar = e.sel ? {30'b0, ret2} : ret1;
      checks++;
      if (av !== e.vec || ar !== e.ret) begin
        errors++;
        $display("FAIL %s dut%0d @%0t: got outputs=%b retired=%0d, expected outputs=%b retired=%0d",
                 e.tag, e.sel + 1, $time, av, ar, e.vec, e.ret);
      end
    end
  end

  initial begin
    sel = 1'b0;
    do_reset();
    instr(6'h00, 0);   // R-type
    instr(6'h23, 3);   // lw with three memory wait cycles
    instr(6'h0D, 0);   // ori: zero-extend
    instr(6'h08, 0);   // addi: sign-extend
    instr(6'h04, 0);   // beq
    instr(6'h02, 0);   // j
    instr(6'h0C, 0);   // andi
    instr(6'h2B, 1);   // sw with one wait cycle
    // sw abandoned by reset while waiting in MEM_WRITE
    op = 6'h2B;
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b0); cyc(S_MADDR, 1'b0); cyc(S_MWRITE, 1'b0);
    do_reset();
    instr(6'h00, 0);
    instr(6'h3F, 19);  // illegal opcode: HALT for 20 cycles
    do_reset();
    op = 6'h00;
    cyc(S_FETCH, 1'b1);

    // Short-counter instance: retired wraps, then FETCH times out after 4 waits.
    sel = 1'b1;
    do_reset();
    repeat (5) instr(6'h02, 0);
    op = 6'h00;
    repeat (4) cyc(S_FETCH, 1'b0);
    repeat (3) cyc(S_HALT, 1'b0);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the multicycle datapath: PC, instruction register, register file, ALU, memory and the 16-to-32-bit immediate extender.
- Decodes the 6-bit opcode held in the instruction register and steps each instruction through fetch, decode, execute, memory and writeback.
- Waits on a memory-ready handshake and counts retired instructions.
- Also drives the extender mode select: zero-extend for andi/ori, sign-extend otherwise.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 255, max cycles waiting on mem_ready before halt; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
opcode  input  6  instruction register bits [31:26]
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero flag is set
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
reg_dst  output  1  destination register: 0 = rt, 1 = rd
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A
alu_src_b  output  2  ALU B input: 00 = B, 01 = 4, 10 = ext_imm, 11 = ext_imm<<2
alu_op  output  2  ALU op: 00 = add, 01 = sub, 10 = funct field, 11 = immediate op from opcode
pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
ext_zero  output  1  extender mode: 1 = zero-extend, 0 = sign-extend
illegal_op  output  1  sticky halt flag, set on undefined opcode or memory timeout
instr_done  output  1  one-cycle pulse when an instruction retires
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (reset_n = 0 at a rising clk edge):
  - state goes to IDLE; timeout counter and retired clear to 0.
  - All outputs are 0.
  - Reset asserted mid-instruction abandons it; any pending memory request drops the next cycle.
- Opcodes: R = 0x00, lw = 0x23, sw = 0x2B, beq = 0x04, j = 0x02, addi = 0x08, andi = 0x0C, ori = 0x0D. Any other value is illegal.
- Every output not listed for a state is 0 in that state.
- States, asserted outputs and transitions:
  - IDLE: all outputs 0 -> FETCH.
  - FETCH:
    - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
    - ir_write and pc_write are 1 only in the cycle with mem_ready = 1 (gated by mem_ready).
    - Stay while mem_ready = 0; go to DECODE on mem_ready = 1.
  - DECODE:
    - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut).
    - Next state by opcode: lw/sw -> MEM_ADDR; R -> EXECUTE; beq -> BRANCH; j -> JUMP; addi/andi/ori -> IMM_EXEC; illegal -> HALT.
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00, ext_zero = 0. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ: mem_read = 1, i_or_d = 1. Wait for mem_ready, then -> MEM_WB.
  - MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0 -> FETCH (retire).
  - MEM_WRITE: mem_write = 1, i_or_d = 1. Wait for mem_ready, then -> FETCH (retire).
  - EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> R_WB.
  - R_WB: reg_write = 1, reg_dst = 1 -> FETCH (retire).
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01 -> FETCH (retire).
  - JUMP: pc_write = 1, pc_source = 10 -> FETCH (retire).
  - IMM_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 11 -> IMM_WB.
  - IMM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0 -> FETCH (retire).
  - HALT: illegal_op = 1, all other outputs 0. Left only by reset.
- ext_zero:
  - 1 in IMM_EXEC and IMM_WB when opcode is andi or ori.
  - 0 for addi and in all other states.
- Retire:
  - instr_done = 1 for exactly one cycle, in the final state of each instruction.
  - retired increments by 1 on that cycle and wraps modulo 2^CNT_W (all-ones -> 0).
- Latency with mem_ready held at 1: R 4, lw 5, sw 4, beq 3, j 3, addi/andi/ori 4 cycles. Each wait cycle on mem_ready adds one cycle.
- Timeout (only when MEM_TIMEOUT > 0):
  - The counter runs while in FETCH, MEM_READ or MEM_WRITE with mem_ready = 0, and clears on state exit.
  - If it reaches MEM_TIMEOUT -> HALT.
- mem_ready is ignored in all other states.
- opcode is sampled only in DECODE, MEM_ADDR and IMM_*, and must be stable from DECODE until retire.

Test Plan:
- Reset, then R-type (opcode 0x00, mem_ready = 1): states IDLE, FETCH, DECODE, EXECUTE, R_WB, FETCH. reg_write = 1 and reg_dst = 1 in R_WB only; instr_done pulses once; retired = 1.
- lw (0x23) with mem_ready low for 3 cycles in MEM_READ: mem_read and i_or_d held at 1 for 4 cycles; then MEM_WB with mem_to_reg = 1 and reg_write = 1. Total 8 cycles; retired increments once.
- ori (0x0D) then addi (0x08): ext_zero = 1 in IMM_EXEC and IMM_WB for ori; ext_zero = 0 throughout addi. alu_src_b = 10 and alu_op = 11 in both IMM_EXEC states.
- beq (0x04) then j (0x02): BRANCH asserts pc_write_cond = 1, pc_source = 01, alu_op = 01; JUMP asserts pc_write = 1, pc_source = 10. Each takes 3 cycles.
- Opcode 0x3F: DECODE -> HALT, illegal_op = 1 held for 20 cycles with mem_read = 0. Then reset_n = 0 for one edge gives IDLE, illegal_op = 0, retired = 0.
- Reset asserted during MEM_WRITE: outputs all 0 the next cycle, retired unchanged-to-0. Separately, MEM_TIMEOUT = 4 with mem_ready stuck at 0 in FETCH: HALT after 4 wait cycles.
